spi_peripheral: RTL and testbench

SPI target front end for the FPGA's host link (SPI mode 0, MSB first). It oversamples SCLK, CS and COPI in the clock_in domain and frames each CS-low transaction: first byte = op code, subsequent bytes = operands. It feeds the register/command decoders via op_code/operand strobes and serialises their response byte onto CIPO. It is the serial-side counterpart of the camera and display register blocks.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_input_sync.sv | 38 +++
 rtl/spi_peripheral.sv | 179 +++++++++++++++++
 tb/tb_spi_peripheral.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI target front end.
//   spi_state_t : transaction framing states
//   BYTE_BITS   : bits per SPI byte
//   CIPO_IDLE   : level driven on CIPO when no response byte is active
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_DESELECT,
    IDLE,
    OPCODE,
    OPERAND
  } spi_state_t;

  localparam int   BYTE_BITS = 8;
  localparam logic CIPO_IDLE = 1'b0;

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: SYNC_STAGES-deep synchroniser with rise/fall detect.
// The same block is used for data signals that must stay delay-matched with
// the edge-detected ones, so level is taken from the stage the detector uses.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (released synchronously upstream)
//   sig   : asynchronous input
//   level : synchronised level
//   rise  : one-cycle pulse on a synchronised 0->1 transition
//   fall  : one-cycle pulse on a synchronised 1->0 transition
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 target front end, MSB first, oversampled in the
// clock_in domain. The first byte of each CS-low transaction is the op code,
// later bytes are operands. A response byte is serialised onto CIPO in the
// byte slot following each completed byte.
// Optional build macro SPI_PERIPHERAL_FRAMING_ERROR_EN adds a saturating count
// of transactions aborted mid-byte (framing_error_count_out).
// Ports:
//   clock_in, reset_n_in            : clock, async active-low reset
//   spi_select_in/clock_in/data_in  : CS (active low), SCLK, COPI
//   spi_data_out                    : CIPO
//   op_code_out, op_code_valid_out  : op code and its valid level
//   operand_out, operand_valid_out  : last operand and its available level
//   operand_count_out               : operands completed this transaction
//   response_in, response_valid_in  : byte for the next CIPO slot
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   spi_select_in,
  input  logic                   spi_clock_in,
  input  logic                   spi_data_in,
  output logic                   spi_data_out,
  output logic [7:0]             op_code_out,
  output logic                   op_code_valid_out,
  output logic [7:0]             operand_out,
  output logic                   operand_valid_out,
  output logic [COUNT_WIDTH-1:0] operand_count_out,
`ifdef SPI_PERIPHERAL_FRAMING_ERROR_EN
  output logic [7:0]             framing_error_count_out,
`endif
  input  logic [7:0]             response_in,
  input  logic                   response_valid_in
);

  function automatic logic [COUNT_WIDTH-1:0] count_sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // Reset: asserted asynchronously, released on a clock_in edge
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Input synchronisers; COPI rides the same pipeline as SCLK
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic copi, copi_rise, copi_fall;
  logic sync_unused;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clock_in), .rst_n(rst_n), .sig(spi_clock_in),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clock_in), .rst_n(rst_n), .sig(spi_select_in),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clock_in), .rst_n(rst_n), .sig(spi_data_in),
    .level(copi), .rise(copi_rise), .fall(copi_fall)
  );

  assign sync_unused = ^{sclk_level, cs_rise, cs_fall, copi_rise, copi_fall};

  // Framing FSM
  spi_state_t state, state_nxt;
  logic [2:0] bit_count;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift;
  logic       tx_arm;
  logic       in_frame;
  logic       byte_end;

  assign in_frame = (state == OPCODE) || (state == OPERAND);
  assign rx_byte  = {rx_shift, copi};
  // A CS rise in the same cycle as the 8th SCLK edge wins: the byte is dropped
  assign byte_end = in_frame && !cs_level && sclk_rise && (bit_count == 3'd7);

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) state <= WAIT_DESELECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_DESELECT: if (cs_level) state_nxt = IDLE;
      IDLE:          if (!cs_level) state_nxt = OPCODE;
      OPCODE: begin
        if (cs_level)      state_nxt = IDLE;
        else if (byte_end) state_nxt = OPERAND;
      end
      OPERAND:       if (cs_level) state_nxt = IDLE;
      default:       state_nxt = WAIT_DESELECT;
    endcase
  end

  // Byte assembly, output strobes and CIPO shifter
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      bit_count         <= 3'd0;
      rx_shift          <= 7'd0;
      tx_shift          <= 8'h00;
      tx_arm            <= 1'b0;
      op_code_out       <= 8'h00;
      op_code_valid_out <= 1'b0;
      operand_out       <= 8'h00;
      operand_valid_out <= 1'b0;
      operand_count_out <= '0;
    end else if (!in_frame || cs_level) begin
      // Outside a transaction (or on CS release): drop partial bytes,
      // clear strobes, keep the last op code / operand values.
      bit_count         <= 3'd0;
      tx_shift          <= 8'h00;
      tx_arm            <= 1'b0;
      op_code_valid_out <= 1'b0;
      operand_valid_out <= 1'b0;
      operand_count_out <= '0;
    end else begin
      if (sclk_rise) begin
        rx_shift  <= rx_byte[6:0];
        bit_count <= bit_count + 3'd1;
        if (bit_count == 3'd7) begin
          tx_arm <= 1'b1;
          if (state == OPCODE) begin
            op_code_out       <= rx_byte;
            op_code_valid_out <= 1'b1;
          end else begin
            operand_out       <= rx_byte;
            operand_valid_out <= 1'b1;
            operand_count_out <= count_sat_inc(operand_count_out);
          end
        end else if (state == OPERAND) begin
          operand_valid_out <= 1'b0;
        end
      end
      // Response is sampled on the first falling edge after a byte, giving
      // the decoder several clock_in cycles after the strobes update.
      if (sclk_fall) begin
        if (tx_arm) begin
          tx_shift <= response_valid_in ? response_in : 8'h00;
          tx_arm   <= 1'b0;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_data_out = (state == OPERAND) ? tx_shift[7] : CIPO_IDLE;

`ifdef SPI_PERIPHERAL_FRAMING_ERROR_EN
  logic frame_abort;

  assign frame_abort = in_frame && cs_level && (bit_count != 3'd0);

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      framing_error_count_out <= 8'h00;
    end else if (frame_abort && (framing_error_count_out != 8'hFF)) begin
      framing_error_count_out <= framing_error_count_out + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed-vector bench for spi_peripheral. A simple SPI
// host drives mode-0 bytes and captures CIPO on each SCLK rising edge; a
// decoder model returns a table-driven response keyed on operand_count_out.
module tb_spi_peripheral;

  logic        clock_in;
  logic        reset_n_in;
  logic        spi_select_in;
  logic        spi_clock_in;
  logic        spi_data_in;
  logic        spi_data_out;
  logic [7:0]  op_code_out;
  logic        op_code_valid_out;
  logic [7:0]  operand_out;
  logic        operand_valid_out;
  logic [31:0] operand_count_out;
`ifdef SPI_PERIPHERAL_FRAMING_ERROR_EN
  logic [7:0]  framing_error_count_out;
`endif
  logic [7:0]  response_in;
  logic        response_valid_in;

  logic [7:0]  resp_tab [4];
  logic [3:0]  resp_vld;

  int vectors;
  int miscompares;
  int ov_rises;
  logic ov_prev;

  spi_peripheral #(.SYNC_STAGES(2), .COUNT_WIDTH(32)) dut (
    .clock_in(clock_in),
    .reset_n_in(reset_n_in),
    .spi_select_in(spi_select_in),
    .spi_clock_in(spi_clock_in),
    .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out),
    .op_code_out(op_code_out),
    .op_code_valid_out(op_code_valid_out),
    .operand_out(operand_out),
    .operand_valid_out(operand_valid_out),
    .operand_count_out(operand_count_out),
`ifdef SPI_PERIPHERAL_FRAMING_ERROR_EN
    .framing_error_count_out(framing_error_count_out),
`endif
    .response_in(response_in),
    .response_valid_in(response_valid_in)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Decoder model: response selected by the current operand count
  always_comb begin
    response_in       = 8'h00;
    response_valid_in = 1'b0;
    if (operand_count_out < 32'd4) begin
      response_in       = resp_tab[operand_count_out[1:0]];
      response_valid_in = resp_vld[operand_count_out[1:0]];
    end
  end

  initial begin
    ov_rises = 0;
    ov_prev  = 1'b0;
  end

  always @(posedge clock_in) begin
    if (operand_valid_out && !ov_prev) ov_rises <= ov_rises + 1;
    ov_prev <= operand_valid_out;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Sends the top n bits of tx MSB first; rx holds CIPO captured at each rise
  task automatic send_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_data_in = tx[7-i];
      #80;
      rx[7-i] = spi_data_out;
      spi_clock_in = 1'b1;
      #80;
      spi_clock_in = 1'b0;
    end
    #40;
  endtask

  task automatic cs_low();
    spi_select_in = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    spi_select_in = 1'b1;
    #160;
  endtask

  logic [7:0] rx;
  int         base;
  logic [7:0] exp_cipo [4];

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_n_in    = 1'b0;
    spi_select_in = 1'b0;
    spi_clock_in  = 1'b0;
    spi_data_in   = 1'b0;
    for (int i = 0; i < 4; i++) resp_tab[i] = 8'h00;
    resp_vld = 4'hF;

    // Reset with a transaction already under way
    #100;
    send_bits(8'hA0, 3, rx);
    check("rst_opcode", {24'd0, op_code_out}, 32'h00);
    check("rst_opvld", {31'd0, op_code_valid_out}, 32'd0);
    check("rst_operand", {24'd0, operand_out}, 32'h00);
    check("rst_ovld", {31'd0, operand_valid_out}, 32'd0);
    check("rst_count", operand_count_out, 32'd0);
    check("rst_cipo", {31'd0, spi_data_out}, 32'd0);
    reset_n_in = 1'b1;
    #100;
    send_bits(8'h0B, 5, rx);
    send_bits(8'h21, 8, rx);
    check("inflight_opvld", {31'd0, op_code_valid_out}, 32'd0);
    check("inflight_opcode", {24'd0, op_code_out}, 32'h00);
    cs_high();
    cs_low();
    send_bits(8'h21, 8, rx);
    check("first_opvld", {31'd0, op_code_valid_out}, 32'd1);
    check("first_opcode", {24'd0, op_code_out}, 32'h21);
    check("first_cipo", {24'd0, rx}, 32'h00);
    cs_high();

    // Op-code only transaction
    cs_low();
    send_bits(8'h20, 8, rx);
    check("op20_cipo", {24'd0, rx}, 32'h00);
    check("op20_opvld", {31'd0, op_code_valid_out}, 32'd1);
    check("op20_count", operand_count_out, 32'd0);
    cs_high();
    check("op20_opvld_csh", {31'd0, op_code_valid_out}, 32'd0);
    check("op20_opcode_hold", {24'd0, op_code_out}, 32'h20);
    check("op20_cipo_csh", {31'd0, spi_data_out}, 32'd0);

    // Single operand
    base = ov_rises;
    cs_low();
    send_bits(8'h26, 8, rx);
    send_bits(8'h0A, 8, rx);
    check("op26_opcode", {24'd0, op_code_out}, 32'h26);
    check("op26_operand", {24'd0, operand_out}, 32'h0A);
    check("op26_ovld", {31'd0, operand_valid_out}, 32'd1);
    check("op26_count", operand_count_out, 32'd1);
    check("op26_rises", ov_rises - base, 32'd1);
    cs_high();
    check("op26_ovld_csh", {31'd0, operand_valid_out}, 32'd0);
    check("op26_count_csh", operand_count_out, 32'd0);
    check("op26_operand_hold", {24'd0, operand_out}, 32'h0A);

    // Read: response slots keyed on operand count
    resp_tab[0] = 8'h12;
    resp_tab[1] = 8'h34;
    cs_low();
    send_bits(8'h21, 8, rx);
    check("rd21_cipo0", {24'd0, rx}, 32'h00);
    send_bits(8'hFF, 8, rx);
    check("rd21_cipo1", {24'd0, rx}, 32'h12);
    send_bits(8'hFF, 8, rx);
    check("rd21_cipo2", {24'd0, rx}, 32'h34);
    check("rd21_count", operand_count_out, 32'd2);
    cs_high();

    // Four slots, third response not valid
    resp_tab[0] = 8'hA5;
    resp_tab[1] = 8'h3C;
    resp_tab[2] = 8'h77;
    resp_tab[3] = 8'hC3;
    resp_vld    = 4'b1011;
    exp_cipo[0] = 8'hA5;
    exp_cipo[1] = 8'h3C;
    exp_cipo[2] = 8'h00;
    exp_cipo[3] = 8'hC3;
    base = ov_rises;
    cs_low();
    send_bits(8'h22, 8, rx);
    for (int k = 0; k < 4; k++) begin
      send_bits(8'h00, 8, rx);
      check($sformatf("rd22_cipo%0d", k), {24'd0, rx}, {24'd0, exp_cipo[k]});
    end
    check("rd22_count", operand_count_out, 32'd4);
    check("rd22_rises", ov_rises - base, 32'd4);
    cs_high();
    resp_vld = 4'hF;

    // CS released mid-operand
    cs_low();
    send_bits(8'h30, 8, rx);
    send_bits(8'h55, 8, rx);
    send_bits(8'hFF, 5, rx);
    check("abort_ovld_mid", {31'd0, operand_valid_out}, 32'd0);
    check("abort_count_mid", operand_count_out, 32'd1);
    cs_high();
    check("abort_operand", {24'd0, operand_out}, 32'h55);
    check("abort_opcode", {24'd0, op_code_out}, 32'h30);
    check("abort_count", operand_count_out, 32'd0);
    check("abort_opvld", {31'd0, op_code_valid_out}, 32'd0);
    check("abort_ovld", {31'd0, operand_valid_out}, 32'd0);
`ifdef SPI_PERIPHERAL_FRAMING_ERROR_EN
    check("abort_ferr", {24'd0, framing_error_count_out}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
